hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard/sequencing controller for the 5-stage RV32I core. Drives stall/bubble controls of
//  D/E/M/W pipe regs and fetch PC hold: load-use interlock, taken-branch flush, multi-cycle mul/div
//  wait, data-memory wait handshake with timeout. Sits beside the pipe regs in the top-level cpu.
// PARAMETERS
//  MD_LATENCY   8    cycles a mul/div occupies E, counted from issue cycle (>=2)
//  MEM_TIMEOUT  16   max consecutive M wait cycles before fatal error (>=2)
// PORTS
//  clk_i         in   1   clock, rising edge
//  rst_i         in   1   synchronous reset, active high
//  D_rs1_i       in   5   rs1 of instr in D
//  D_rs2_i       in   5   rs2 of instr in D
//  D_use_rs1_i   in   1   D instr reads rs1
//  D_use_rs2_i   in   1   D instr reads rs2
//  E_opcode_i    in   7   opcode of instr in E (load = 7'b0000011)
//  E_rd_i        in   5   rd of instr in E
//  E_branch_i    in   1   E instr is branch/jal/jalr
//  E_cnd_i       in   1   E branch taken (predict-not-taken, so taken = mispredict)
//  E_md_start_i  in   1   mul/div instr present in E this cycle
//  M_req_i       in   1   M stage data-memory request
//  M_ready_i     in   1   data memory completes request this cycle
//  F_stall_o     out  1   hold PC
//  D_stall_o     out  1   hold D reg
//  D_bubble_o    out  1   load nop into D reg
//  E_stall_o     out  1   hold E reg
//  E_bubble_o    out  1   load nop into E reg
//  M_stall_o     out  1   hold M reg
//  M_bubble_o    out  1   load nop into M reg
//  W_bubble_o    out  1   load nop into W reg
//  md_busy_o     out  1   state == MDWAIT
//  err_o         out  1   sticky memory-timeout error
// BEHAVIOUR
//  - States: RUN=0, MDWAIT=1, MEMWAIT=2, HALT=3. Outputs Mealy: f(state, inputs); state/counters regd.
//  - Reset (rst_i=1 at edge): state RUN, md_cnt=0, mem_cnt=0, err_o=0. While rst_i=1 all stalls=0,
//    all bubbles=1, md_busy_o=0.
//  - Events this cycle: memw = M_req_i & !M_ready_i; flush = E_branch_i & E_cnd_i;
//    lduse = (E_opcode_i==LOAD) & E_rd_i!=0 & ((D_use_rs1_i & D_rs1_i==E_rd_i)|(D_use_rs2_i & D_rs2_i==E_rd_i)).
//  - RUN priority memw > flush > E_md_start_i > lduse:
//    memw: F,D,E,M stall, W_bubble; next MEMWAIT, mem_cnt<=1.
//    flush: D_bubble, E_bubble; stay RUN. lduse ignored (D instr squashed).
//    md_start: F,D,E stall, M_bubble; md_cnt<=MD_LATENCY-2; next MDWAIT.
//    lduse: F,D stall, E_bubble (exactly 1 cycle); stay RUN.
//    none: all controls 0.
//  - MDWAIT: F,D,E stall, M_bubble. If memw (older op in M): additionally M stall, W_bubble, M_bubble=0,
//    md_cnt frozen. Else md_cnt==0 -> RUN (release, total stall = MD_LATENCY cycles incl. issue),
//    else md_cnt-=1. E_md_start_i ignored in MDWAIT.
//  - MEMWAIT: F,D,E,M stall, W_bubble while !M_ready_i; mem_cnt+=1.
//    M_ready_i=1 -> controls as RUN with memw=0, same cycle; next state per RUN rules.
//    mem_cnt==MEM_TIMEOUT-1 and still !M_ready_i -> next HALT, err_o<=1.
//  - HALT: F,D,E,M stall, W_bubble, err_o=1 held; only rst_i exits.
//  - Stall and bubble never both 1 on the same reg. Counters saturate, never wrap.
//  - rst_i mid-MDWAIT/MEMWAIT: abandon op, RUN next cycle, counters cleared.
// TESTING
//  1 lw x5 in E, D add x6,x5,x1 (use rs1) -> F/D_stall=1, E_bubble=1 one cycle; rd=x0 -> no stall.
//  2 E_branch_i=1,E_cnd_i=1 with simultaneous lduse -> D_bubble=E_bubble=1, F_stall=0, no stall next.
//  3 E_md_start_i=1 in RUN, MD_LATENCY=8 -> E_stall=1 and md_busy for cycles 0..7 (busy 1..7), RUN at 8.
//  4 M_req_i=1, M_ready_i low 3 cycles then high -> M_stall=W_bubble=1 for 3 cycles, clear on ready.
//  5 M_ready_i held 0 for 16 cycles -> HALT, err_o=1 sticky; rst_i -> err_o=0, state RUN.
//  6 memw during MDWAIT (md_cnt=3) -> md_cnt frozen; release exactly 3+1 cycles after ready.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard-controller signal bundle: pipe-stage hazard inputs and pipe-reg stall/bubble controls.
interface hazard_ctrl_if;
  logic [4:0] D_rs1_i;
  logic [4:0] D_rs2_i;
  logic       D_use_rs1_i;
  logic       D_use_rs2_i;
  logic [6:0] E_opcode_i;
  logic [4:0] E_rd_i;
  logic       E_branch_i;
  logic       E_cnd_i;
  logic       E_md_start_i;
  logic       M_req_i;
  logic       M_ready_i;
  logic       F_stall_o;
  logic       D_stall_o;
  logic       D_bubble_o;
  logic       E_stall_o;
  logic       E_bubble_o;
  logic       M_stall_o;
  logic       M_bubble_o;
  logic       W_bubble_o;
  logic       md_busy_o;
  logic       err_o;

  modport master (
    output D_rs1_i, D_rs2_i, D_use_rs1_i, D_use_rs2_i, E_opcode_i, E_rd_i,
           E_branch_i, E_cnd_i, E_md_start_i, M_req_i, M_ready_i,
    input  F_stall_o, D_stall_o, D_bubble_o, E_stall_o, E_bubble_o,
           M_stall_o, M_bubble_o, W_bubble_o, md_busy_o, err_o
  );

  modport slave (
    input  D_rs1_i, D_rs2_i, D_use_rs1_i, D_use_rs2_i, E_opcode_i, E_rd_i,
           E_branch_i, E_cnd_i, E_md_start_i, M_req_i, M_ready_i,
    output F_stall_o, D_stall_o, D_bubble_o, E_stall_o, E_bubble_o,
           M_stall_o, M_bubble_o, W_bubble_o, md_busy_o, err_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch flush, mul/div wait and
// data-memory wait with sticky timeout error. Controls are Mealy on registered state.
module hazard_ctrl #(
  parameter int unsigned MD_LATENCY  = 8,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  hazard_ctrl_if.slave hz
);
  localparam int unsigned MD_W  = $clog2(MD_LATENCY + 1);
  localparam int unsigned MEM_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [6:0]  OP_LOAD = 7'b0000011;

  typedef enum logic [1:0] {RUN = 2'd0, MDWAIT = 2'd1, MEMWAIT = 2'd2, HALT = 2'd3} state_e;

  state_e           state_q, state_d;
  logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
  logic [MEM_W-1:0] mem_cnt_q, mem_cnt_d;
  logic             err_q, err_d;

  logic memw, flush, lduse;
  logic f_stall, d_stall, d_bubble, e_stall, e_bubble, m_stall, m_bubble, w_bubble;

  always_comb begin
    memw  = hz.M_req_i & ~hz.M_ready_i;
    flush = hz.E_branch_i & hz.E_cnd_i;
    lduse = (hz.E_opcode_i == OP_LOAD) && (hz.E_rd_i != 5'd0) &&
            ((hz.D_use_rs1_i && (hz.D_rs1_i == hz.E_rd_i)) ||
             (hz.D_use_rs2_i && (hz.D_rs2_i == hz.E_rd_i)));
  end

  // Next-state, counters and pipe controls
  always_comb begin
    state_d   = state_q;
    md_cnt_d  = md_cnt_q;
    mem_cnt_d = mem_cnt_q;
    err_d     = err_q;
    f_stall   = 1'b0;
    d_stall   = 1'b0;
    d_bubble  = 1'b0;
    e_stall   = 1'b0;
    e_bubble  = 1'b0;
    m_stall   = 1'b0;
    m_bubble  = 1'b0;
    w_bubble  = 1'b0;

    unique case (state_q)
      RUN, MEMWAIT: begin
        if (state_q == MEMWAIT && !hz.M_ready_i) begin
          {f_stall, d_stall, e_stall, m_stall, w_bubble} = 5'b11111;
          if (mem_cnt_q >= MEM_W'(MEM_TIMEOUT - 1)) begin
            state_d = HALT;
            err_d   = 1'b1;
          end else begin
            mem_cnt_d = mem_cnt_q + MEM_W'(1);
          end
        end else begin
          // A completing memory wait resolves exactly like RUN with no memw
          state_d   = RUN;
          mem_cnt_d = '0;
          if (memw) begin
            {f_stall, d_stall, e_stall, m_stall, w_bubble} = 5'b11111;
            state_d   = MEMWAIT;
            mem_cnt_d = MEM_W'(1);
          end else if (flush) begin
            d_bubble = 1'b1;
            e_bubble = 1'b1;
          end else if (hz.E_md_start_i) begin
            {f_stall, d_stall, e_stall, m_bubble} = 4'b1111;
            md_cnt_d = MD_W'(MD_LATENCY - 2);
            state_d  = MDWAIT;
          end else if (lduse) begin
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            e_bubble = 1'b1;
          end
        end
      end
      MDWAIT: begin
        {f_stall, d_stall, e_stall} = 3'b111;
        if (memw) begin
          // Older op stuck in M: freeze the mul/div count until memory completes
          m_stall  = 1'b1;
          w_bubble = 1'b1;
        end else begin
          m_bubble = 1'b1;
          if (md_cnt_q == '0) state_d = RUN;
          else                md_cnt_d = md_cnt_q - MD_W'(1);
        end
      end
      HALT: begin
        {f_stall, d_stall, e_stall, m_stall, w_bubble} = 5'b11111;
      end
      default: state_d = RUN;
    endcase

    if (rst_i) begin
      {f_stall, d_stall, e_stall, m_stall}     = 4'b0000;
      {d_bubble, e_bubble, m_bubble, w_bubble} = 4'b1111;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      md_cnt_q  <= '0;
      mem_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      md_cnt_q  <= md_cnt_d;
      mem_cnt_q <= mem_cnt_d;
      err_q     <= err_d;
    end
  end

  assign hz.F_stall_o  = f_stall;
  assign hz.D_stall_o  = d_stall;
  assign hz.D_bubble_o = d_bubble;
  assign hz.E_stall_o  = e_stall;
  assign hz.E_bubble_o = e_bubble;
  assign hz.M_stall_o  = m_stall;
  assign hz.M_bubble_o = m_bubble;
  assign hz.W_bubble_o = w_bubble;
  assign hz.md_busy_o  = (state_q == MDWAIT) && !rst_i;
  assign hz.err_o      = err_q;
endmodule
